// File: rtl/instruction_pointer_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_pointer_unit
//  Description : Architectural EIP/IP holder with sequencing logic. Advances
//                the pointer by the retiring instruction length, loads
//                absolute or relative branch targets, applies 16/32-bit wrap,
//                checks the new pointer against the code-segment limit and
//                keeps a one-deep restart point for fault recovery.
//                Sits between decode/execute and prefetch; o_eip drives the
//                fetch offset.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH          pointer width in bits (>= 16)
//    RESET_VECTOR   EIP value after reset (truncated/extended to WIDTH)
//    LEN_W          width of the instruction length field
//  Ports
//    i_clk              clock, rising edge
//    i_rst              asynchronous, active-high reset
//    i_mode32           1: 32-bit offsets, 0: 16-bit IP (wrap mod 2**16)
//    i_advance_valid    retire current instruction, step by i_advance_length
//    i_advance_length   byte length of the retiring instruction
//    i_branch_valid     load new pointer (beats plain advance)
//    i_branch_relative  1: EIP + length + target, 0: absolute target
//    i_branch_target    absolute target or two's-complement displacement
//    i_fault_valid      restore EIP to the last restart point
//    i_cs_limit         code segment limit (inclusive)
//    o_eip              current instruction offset
//    o_ip               low 16 bits of o_eip
//    o_last_eip         restart point (offset of last retired/branched-from)
//    o_limit_fault      one-cycle pulse: requested pointer exceeded limit
// ============================================================================
module instruction_pointer_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_FFF0,
  parameter int          LEN_W        = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mode32,
  input  logic             i_advance_valid,
  input  logic [LEN_W-1:0] i_advance_length,
  input  logic             i_branch_valid,
  input  logic             i_branch_relative,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_fault_valid,
  input  logic [WIDTH-1:0] i_cs_limit,
  output logic [WIDTH-1:0] o_eip,
  output logic [15:0]      o_ip,
  output logic [WIDTH-1:0] o_last_eip,
  output logic             o_limit_fault
);

  localparam logic [WIDTH-1:0] c_RESET_EIP = WIDTH'(RESET_VECTOR);
  // Keeps only the low 16 bits; expressed as a mask so WIDTH == 16 works.
  localparam logic [WIDTH-1:0] c_MASK16    = WIDTH'(17'h0FFFF);

  logic [WIDTH-1:0] r_eip;
  logic [WIDTH-1:0] r_last_eip;
  logic             r_limit_fault;

  logic [WIDTH-1:0] w_len_ext;
  logic [WIDTH-1:0] w_next_seq;
  logic [WIDTH-1:0] w_rel_target;
  logic [WIDTH-1:0] w_cand_raw;
  logic [WIDTH-1:0] w_cand;
  logic             w_request;
  logic             w_over_limit;

  // --------------------------------------------------------------------------
  // Candidate pointer
  // --------------------------------------------------------------------------
  assign w_len_ext    = WIDTH'(i_advance_length);
  assign w_next_seq   = r_eip + w_len_ext;
  // Relative branches are taken from the end of the branch instruction, so
  // the length is always included whether or not advance is also asserted.
  assign w_rel_target = w_next_seq + i_branch_target;

  always_comb begin
    w_cand_raw = w_next_seq;
    if (i_branch_valid) begin
      w_cand_raw = i_branch_relative ? w_rel_target : i_branch_target;
    end
  end

  // Masking the full-width sum is equivalent to 16-bit modular arithmetic,
  // and also clears the upper half of an absolute target in 16-bit mode.
  assign w_cand       = i_mode32 ? w_cand_raw : (w_cand_raw & c_MASK16);
  assign w_over_limit = (w_cand > i_cs_limit);
  assign w_request    = i_branch_valid | i_advance_valid;

  // --------------------------------------------------------------------------
  // Pointer state: fault > branch > advance > hold
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_eip         <= c_RESET_EIP;
      r_last_eip    <= c_RESET_EIP;
      r_limit_fault <= 1'b0;
    end else begin
      r_limit_fault <= 1'b0;
      if (i_fault_valid) begin
        // Restart point is kept so a repeated fault returns to the same place.
        r_eip <= r_last_eip;
      end else if (w_request) begin
        if (w_over_limit) begin
          r_limit_fault <= 1'b1;
        end else begin
          r_last_eip <= r_eip;
          r_eip      <= w_cand;
        end
      end
    end
  end

  assign o_eip         = r_eip;
  assign o_ip          = r_eip[15:0];
  assign o_last_eip    = r_last_eip;
  assign o_limit_fault = r_limit_fault;

endmodule
`default_nettype wire
